// File: rtl/pool_max_writer.sv
// Pooling-stage consumer: aligns the iterator's window tags with the SRAM read data,
// takes the signed max over each window and writes one result per window to sequential addresses.
module pool_max_writer #(
    parameter int          DATA_W    = 16,
    parameter int          MEM_LAT   = 1,
    parameter int          NUM_OUT   = 2880,
    parameter logic [11:0] BASE_ADDR = 12'd0,
    parameter bit          RELU      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              cena_in,
    input  logic              first_in,
    input  logic              last_in,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [11:0]       wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FIRST,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic [11:0] LAST_IDX = 12'(NUM_OUT - 1);

    // Each stage holds {valid, first, last}; stage MEM_LAT-1 lines up with rd_data.
    logic [2:0] dly_q [MEM_LAT];
    logic [2:0] dly_d [MEM_LAT];

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  acc_q, acc_d;
    logic [11:0]               cnt_q, cnt_d;
    logic [11:0]               addr_q, addr_d;
    logic                      wr_en_q, wr_en_d;
    logic [11:0]               wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]         wr_data_q, wr_data_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic                      d_v, d_first, d_last;
    logic signed [DATA_W-1:0]  rd_s, max_val, wr_val;
    logic                      do_write;

    assign d_v     = dly_q[MEM_LAT-1][2];
    assign d_first = dly_q[MEM_LAT-1][1];
    assign d_last  = dly_q[MEM_LAT-1][0];
    assign rd_s    = signed'(rd_data);
    assign max_val = (rd_s > acc_q) ? rd_s : acc_q;

    // The iterator parks first/last high while idle, so tags are qualified before delaying.
    always_comb begin
        dly_d[0] = {~cena_in, first_in & ~cena_in, last_in & ~cena_in};
        for (int i = 1; i < MEM_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    always_comb begin
        // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        do_write  = 1'b0;
        wr_val    = rd_s;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d   = S_WAIT_FIRST;
                    cnt_d     = '0;
                    addr_d    = BASE_ADDR;
                    wr_addr_d = BASE_ADDR;
                    acc_d     = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_WAIT_FIRST: begin
                if (d_v) begin
                    if (!d_first) begin
                        err_d = 1'b1;
                    end else if (d_last) begin
                        do_write = 1'b1;
                    end else begin
                        acc_d   = rd_s;
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (d_v) begin
                    if (d_first) begin
                        // A fresh first beat abandons the open window and starts over.
                        err_d = 1'b1;
                        if (d_last) begin
                            do_write = 1'b1;
                            state_d  = S_WAIT_FIRST;
                        end else begin
                            acc_d = rd_s;
                        end
                    end else if (d_last) begin
                        do_write = 1'b1;
                        wr_val   = max_val;
                        state_d  = S_WAIT_FIRST;
                    end else begin
                        acc_d = max_val;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_data_d = (RELU && wr_val[DATA_W-1]) ? '0 : wr_val;
            wr_addr_d = addr_q;
            addr_d    = addr_q + 12'd1;
            cnt_d     = cnt_q + 12'd1;
            if (cnt_q == LAST_IDX) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag delay line is a handful of flops, so it is reset explicitly; stale tags must not survive an abort.
            for (int i = 0; i < MEM_LAT; i++) begin
                dly_q[i] <= '0;
            end
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= BASE_ADDR;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE_ADDR;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            dly_q     <= dly_d;
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_pool_max_writer.sv
// Directed bench for pool_max_writer: four configurations (plain, RELU, 1x1 windows, MEM_LAT=2),
// each fed by its own stimulus and a bench-side SRAM latency pipe.
module tb_pool_max_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance k: 0 = LAT1/NUM2, 1 = RELU/NUM2, 2 = NUM4 1x1, 3 = LAT2/NUM2
    logic               go_s    [4];
    logic               cena_s  [4];
    logic               first_s [4];
    logic               last_s  [4];
    logic signed [15:0] src_s   [4];
    logic signed [15:0] p1      [4];
    logic signed [15:0] p2      [4];
    logic               wr_en_o [4];
    logic [11:0]        wr_addr_o [4];
    logic signed [15:0] wr_data_o [4];
    logic               busy_o  [4];
    logic               done_o  [4];
    logic               err_o   [4];

    int checks = 0;
    int errors = 0;

    // Bench model of the SRAM read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            p1[k] <= src_s[k];
            p2[k] <= p1[k];
        end
    end

    pool_max_writer #(.DATA_W(16), .MEM_LAT(1), .NUM_OUT(2), .BASE_ADDR(12'd0), .RELU(1'b0)) u_a (
        .clk(clk), .rst(rst), .go(go_s[0]), .cena_in(cena_s[0]), .first_in(first_s[0]),
        .last_in(last_s[0]), .rd_data(p1[0]), .wr_en(wr_en_o[0]), .wr_addr(wr_addr_o[0]),
        .wr_data(wr_data_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]));

    pool_max_writer #(.DATA_W(16), .MEM_LAT(1), .NUM_OUT(2), .BASE_ADDR(12'd0), .RELU(1'b1)) u_b (
        .clk(clk), .rst(rst), .go(go_s[1]), .cena_in(cena_s[1]), .first_in(first_s[1]),
        .last_in(last_s[1]), .rd_data(p1[1]), .wr_en(wr_en_o[1]), .wr_addr(wr_addr_o[1]),
        .wr_data(wr_data_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]));

    pool_max_writer #(.DATA_W(16), .MEM_LAT(1), .NUM_OUT(4), .BASE_ADDR(12'd0), .RELU(1'b0)) u_c (
        .clk(clk), .rst(rst), .go(go_s[2]), .cena_in(cena_s[2]), .first_in(first_s[2]),
        .last_in(last_s[2]), .rd_data(p1[2]), .wr_en(wr_en_o[2]), .wr_addr(wr_addr_o[2]),
        .wr_data(wr_data_o[2]), .busy(busy_o[2]), .done(done_o[2]), .err(err_o[2]));

    pool_max_writer #(.DATA_W(16), .MEM_LAT(2), .NUM_OUT(2), .BASE_ADDR(12'd0), .RELU(1'b0)) u_d (
        .clk(clk), .rst(rst), .go(go_s[3]), .cena_in(cena_s[3]), .first_in(first_s[3]),
        .last_in(last_s[3]), .rd_data(p2[3]), .wr_en(wr_en_o[3]), .wr_addr(wr_addr_o[3]),
        .wr_data(wr_data_o[3]), .busy(busy_o[3]), .done(done_o[3]), .err(err_o[3]));

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        cena_s[k]  = 1'b1;
        first_s[k] = 1'b1;
        last_s[k]  = 1'b1;
        src_s[k]   = 16'sh7fff;
    endtask

    task automatic send(input int k, input bit f, input bit l, input logic signed [15:0] d);
        cena_s[k]  = 1'b0;
        first_s[k] = f;
        last_s[k]  = l;
        src_s[k]   = d;
        step();
    endtask

    task automatic gap(input int k);
        idle(k);
        step();
    endtask

    task automatic pulse_go(input int k);
        go_s[k] = 1'b1;
        step();
        go_s[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            go_s[k] = 1'b0;
            idle(k);
        end
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_wr_en",   wr_en_o[0], 0);
        check("rst_wr_addr", wr_addr_o[0], 0);
        check("rst_wr_data", wr_data_o[0], 0);
        check("rst_busy",    busy_o[0], 0);
        check("rst_done",    done_o[0], 0);
        check("rst_err",     err_o[0], 0);

        // ---- Instance A: 2x2 windows {3,9,-1,4} -> 9@0, {-5,-7,-2,-6} -> -2@1
        pulse_go(0);
        check("a_busy", busy_o[0], 1);
        send(0, 1, 0, 16'sd3);
        go_s[0] = 1'b1;                 // ignored while busy
        send(0, 0, 0, 16'sd9);
        go_s[0] = 1'b0;
        gap(0);                          // invalid beat with flags high and junk data
        send(0, 0, 0, -16'sd1);
        send(0, 0, 1, 16'sd4);
        idle(0);
        step();
        check("a_w0_en",   wr_en_o[0], 1);
        check("a_w0_data", wr_data_o[0], 9);
        check("a_w0_addr", wr_addr_o[0], 0);
        check("a_w0_err",  err_o[0], 0);
        step();
        check("a_w0_pulse", wr_en_o[0], 0);
        check("a_w0_nodone", done_o[0], 0);
        send(0, 1, 0, -16'sd5);
        send(0, 0, 0, -16'sd7);
        send(0, 0, 0, -16'sd2);
        send(0, 0, 1, -16'sd6);
        idle(0);
        step();
        check("a_w1_en",   wr_en_o[0], 1);
        check("a_w1_data", wr_data_o[0], -2);
        check("a_w1_addr", wr_addr_o[0], 1);
        check("a_w1_done_early", done_o[0], 0);
        step();
        check("a_done",      done_o[0], 1);
        check("a_done_busy", busy_o[0], 0);
        check("a_done_wr",   wr_en_o[0], 0);
        step();
        check("a_done_pulse", done_o[0], 0);

        // Beat without first while waiting -> sticky err, beat dropped
        pulse_go(0);
        send(0, 0, 0, 16'sd5);
        idle(0);
        step();
        check("a_err_set", err_o[0], 1);
        check("a_err_nowr", wr_en_o[0], 0);
        send(0, 1, 1, 16'sd7);
        idle(0);
        step();
        check("a_err_w_en",   wr_en_o[0], 1);
        check("a_err_w_data", wr_data_o[0], 7);
        check("a_err_w_addr", wr_addr_o[0], 0);
        check("a_err_sticky", err_o[0], 1);

        // Reset mid-window, then a restart
        send(0, 1, 0, 16'sd1);
        send(0, 0, 0, 16'sd2);
        idle(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("a_rst_busy", busy_o[0], 0);
        check("a_rst_err",  err_o[0], 0);
        check("a_rst_addr", wr_addr_o[0], 0);
        send(0, 0, 1, 16'sd50);          // stray last beat while idle
        idle(0);
        step();
        check("a_rst_nostale", wr_en_o[0], 0);
        check("a_rst_idle_err", err_o[0], 0);
        pulse_go(0);
        send(0, 1, 0, 16'sd11);
        send(0, 0, 1, 16'sd12);
        idle(0);
        step();
        check("a_rst_w_en",   wr_en_o[0], 1);
        check("a_rst_w_data", wr_data_o[0], 12);
        check("a_rst_w_addr", wr_addr_o[0], 0);
        check("a_rst_w_err",  err_o[0], 0);

        // ---- Instance B: RELU
        pulse_go(1);
        send(1, 1, 0, -16'sd3);
        send(1, 0, 0, -16'sd8);
        send(1, 0, 0, -16'sd1);
        send(1, 0, 1, -16'sd4);
        idle(1);
        step();
        check("b_w0_en",   wr_en_o[1], 1);
        check("b_w0_data", wr_data_o[1], 0);
        send(1, 1, 0, -16'sd3);
        send(1, 0, 1, 16'sd5);
        idle(1);
        step();
        check("b_w1_en",   wr_en_o[1], 1);
        check("b_w1_data", wr_data_o[1], 5);
        check("b_w1_addr", wr_addr_o[1], 1);
        step();
        check("b_done", done_o[1], 1);

        // ---- Instance C: 1x1 windows back to back
        pulse_go(2);
        send(2, 1, 1, 16'sd1);
        send(2, 1, 1, 16'sd2);
        check("c_w0_en",   wr_en_o[2], 1);
        check("c_w0_data", wr_data_o[2], 1);
        check("c_w0_addr", wr_addr_o[2], 0);
        send(2, 1, 1, 16'sd3);
        check("c_w1_en",   wr_en_o[2], 1);
        check("c_w1_data", wr_data_o[2], 2);
        check("c_w1_addr", wr_addr_o[2], 1);
        send(2, 1, 1, 16'sd4);
        check("c_w2_data", wr_data_o[2], 3);
        check("c_w2_addr", wr_addr_o[2], 2);
        idle(2);
        step();
        check("c_w3_en",   wr_en_o[2], 1);
        check("c_w3_data", wr_data_o[2], 4);
        check("c_w3_addr", wr_addr_o[2], 3);
        check("c_w3_nodone", done_o[2], 0);
        step();
        check("c_done",  done_o[2], 1);
        check("c_wr_off", wr_en_o[2], 0);

        // ---- Instance D: MEM_LAT=2 with gaps carrying junk
        pulse_go(3);
        send(3, 1, 0, 16'sd10);
        gap(3);
        send(3, 0, 0, 16'sd20);
        gap(3);
        gap(3);
        send(3, 0, 1, 16'sd15);
        idle(3);
        step();
        check("d_w0_lat", wr_en_o[3], 0);
        step();
        check("d_w0_en",   wr_en_o[3], 1);
        check("d_w0_data", wr_data_o[3], 20);
        check("d_w0_addr", wr_addr_o[3], 0);
        send(3, 1, 0, -16'sd100);
        gap(3);
        send(3, 0, 1, -16'sd200);
        idle(3);
        step();
        step();
        check("d_w1_en",   wr_en_o[3], 1);
        check("d_w1_data", wr_data_o[3], -100);
        check("d_w1_addr", wr_addr_o[3], 1);
        step();
        check("d_done", done_o[3], 1);
        check("d_err",  err_o[3], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
